// File: rtl/dram_line_responder.sv
// dram_line_responder: main-memory model behind the L1 cache line port.
// Accepts one 256-bit line read or write at a time, waits a fixed latency
// counted down from acceptance, then pulses dram_ack for one cycle.
// Optional build macro DRAM_LINE_RESPONDER_STATS_EN adds read/write
// completion counters (rd_count, wr_count).
// Debug: fsm_state exposes the controller state (0 IDLE, 1 BUSY, 2 ACK).
//
// Handshake: the cache raises dram_cs (with dram_we/dram_addr/dram_data_i)
// and holds it until it sees dram_ack. A request is taken only at a rising
// edge where the responder is IDLE; all request fields are captured at that
// edge and ignored afterwards. dram_ack is high for exactly one cycle, and
// dram_data_o carries the read line from that cycle until the next read ends.
module dram_line_responder #(
  parameter int addr_width      = 32,
  parameter int mem_data_width  = 256,
  parameter int line_addr_width = 10,
  parameter int latency         = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [addr_width-1:0]     dram_addr,
  input  logic                      dram_cs,
  input  logic                      dram_we,
  output logic                      dram_ack,
  input  logic [mem_data_width-1:0] dram_data_i,
  output logic [mem_data_width-1:0] dram_data_o,
  output logic                      dram_busy,
`ifdef DRAM_LINE_RESPONDER_STATS_EN
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count,
`endif
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int         depth  = 2 ** line_addr_width;
  // Counter is loaded with latency-1 so the BUSY->ACK edge lands at E0+latency.
  localparam logic [7:0] lat_m1 = 8'(latency - 1);

  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d;
  logic [line_addr_width-1:0] idx_q;
  logic [line_addr_width-1:0] line_idx;
  logic                       we_q;
  logic [mem_data_width-1:0]  wdata_q;
  logic                       accept;
  logic                       complete;
  logic [mem_data_width-1:0]  mem [depth];

  // Byte offset and bits above the line index are don't-care (lines alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dram_addr[4:0], dram_addr[addr_width-1:5+line_addr_width]};
  assign line_idx         = dram_addr[5+line_addr_width-1:5];

  assign dram_ack  = (state_q == ACK);
  assign dram_busy = (state_q != IDLE);
  assign fsm_state = state_q;

  // Next-state logic: accept in IDLE, count down in BUSY, single ACK cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (dram_cs) begin
          accept  = 1'b1;
          cnt_d   = lat_m1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          complete = 1'b1;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter, captured request and read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      dram_data_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= line_idx;
        we_q    <= dram_we;
        wdata_q <= dram_data_i;
      end
      if (complete && !we_q) begin
        dram_data_o <= mem[idx_q];
      end
    end
  end

  // Line storage; not reset so contents survive rst. A reset during BUSY
  // forces IDLE, so complete never fires and the pending write is dropped.
  always_ff @(posedge clk) begin
    if (complete && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef DRAM_LINE_RESPONDER_STATS_EN
  // Completion counters, bumped as each request leaves its ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state_q == ACK) begin
      if (we_q) wr_count <= wr_count + 32'd1;
      else      rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_line_responder.sv
// Testbench for dram_line_responder: directed requests against a
// cycle-numbered reference model, plus literal expectations per scenario.
module tb_dram_line_responder;

  localparam int LAT = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (latency 10)
  logic [31:0]  dram_addr = '0;
  logic         dram_cs = 1'b0;
  logic         dram_we = 1'b0;
  logic         dram_ack;
  logic [255:0] dram_data_i = '0;
  logic [255:0] dram_data_o;
  logic         dram_busy;
  logic [1:0]   fsm_state;

  // Second DUT (latency 1)
  logic [31:0]  f_addr = '0;
  logic         f_cs = 1'b0;
  logic         f_we = 1'b0;
  logic         f_ack;
  logic [255:0] f_data_i = '0;
  logic [255:0] f_data_o;
  logic         f_busy;
  logic [1:0]   f_state;

`ifdef DRAM_LINE_RESPONDER_STATS_EN
  logic [31:0] rd_count, wr_count, f_rd_count, f_wr_count;
`endif

  dram_line_responder #(.latency(LAT)) u_dut (
    .clk(clk), .rst(rst), .dram_addr(dram_addr), .dram_cs(dram_cs), .dram_we(dram_we),
    .dram_ack(dram_ack), .dram_data_i(dram_data_i), .dram_data_o(dram_data_o),
    .dram_busy(dram_busy),
`ifdef DRAM_LINE_RESPONDER_STATS_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .fsm_state(fsm_state)
  );

  dram_line_responder #(.latency(1)) u_fast (
    .clk(clk), .rst(rst), .dram_addr(f_addr), .dram_cs(f_cs), .dram_we(f_we),
    .dram_ack(f_ack), .dram_data_i(f_data_i), .dram_data_o(f_data_o),
    .dram_busy(f_busy),
`ifdef DRAM_LINE_RESPONDER_STATS_EN
    .rd_count(f_rd_count), .wr_count(f_wr_count),
`endif
    .fsm_state(f_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works in edge numbers: a request taken at edge E0 is due at E0+LAT
  // (line moved, ack visible after it) and retired at E0+LAT+1.
  logic [255:0] m_mem [int];
  int           cyc = 0;
  bit           m_inflight = 1'b0;
  int           m_due = 0;
  bit           m_we = 1'b0;
  int           m_idx = 0;
  logic [255:0] m_wdata = '0;
  logic [255:0] exp_data = '0;
  bit           exp_ack = 1'b0;
  bit           exp_busy = 1'b0;
  int           m_rd = 0;
  int           m_wr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_inflight = 1'b0;
      exp_data   = '0;
      exp_ack    = 1'b0;
      exp_busy   = 1'b0;
      m_rd       = 0;
      m_wr       = 0;
    end else begin
      cyc++;
      if (!m_inflight) begin
        if (dram_cs) begin
          m_inflight = 1'b1;
          m_due      = cyc + LAT;
          m_we       = dram_we;
          m_idx      = int'(dram_addr[14:5]);
          m_wdata    = dram_data_i;
        end
      end else if (cyc == m_due) begin
        if (m_we) m_mem[m_idx] = m_wdata;
        else      exp_data = m_mem.exists(m_idx) ? m_mem[m_idx] : '0;
      end else if (cyc == m_due + 1) begin
        m_inflight = 1'b0;
        if (m_we) m_wr++;
        else      m_rd++;
      end
      exp_ack  = m_inflight && (cyc == m_due);
      exp_busy = m_inflight;
    end
  end

  // Compare process: every mid-cycle, main DUT outputs against the model.
  always @(negedge clk) begin
    check("ack", dram_ack, exp_ack);
    check("busy", dram_busy, exp_busy);
    check("data_o", dram_data_o, exp_data);
`ifdef DRAM_LINE_RESPONDER_STATS_EN
    check("rd_count", rd_count, m_rd);
    check("wr_count", wr_count, m_wr);
`endif
  end

  // ---------------- driver tasks ----------------
  // Issue one request; pre = edges that pass before the accepting edge.
  // During BUSY the request fields are scrambled to show they are latched.
  task automatic req(input logic we, input logic [31:0] addr, input logic [255:0] d,
                     input logic [255:0] d_busy, input int pre, input bit hold,
                     output int lat, output logic [255:0] rdata);
    dram_cs     = 1'b1;
    dram_we     = we;
    dram_addr   = addr;
    dram_data_i = d;
    repeat (pre + 1) begin @(posedge clk); #1; end
    dram_data_i = d_busy;
    dram_addr   = addr ^ 32'h0000_0080;
    dram_we     = ~we;
    lat = 0;
    while (!dram_ack && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!dram_ack) check("ack_timeout", dram_ack, 1'b1);
    rdata = dram_data_o;
    if (!hold) begin
      dram_cs = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #5 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  logic [255:0] dead = {8{32'hDEADBEEF}};
  logic [255:0] rd;
  int           lat;
  int           acks_seen;

  initial begin
    // Reset values are visible without any clock edge.
    #1;
    check("rst_ack", dram_ack, 1'b0);
    check("rst_busy", dram_busy, 1'b0);
    check("rst_data", dram_data_o, '0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    // Write then read of the same line, plus an aliased address.
    req(1'b1, 32'h0000_0420, dead, ~dead, 0, 1'b0, lat, rd);
    check("wr_latency", lat, 10);
    check("wr_keeps_data_o", rd, '0);
    req(1'b0, 32'h0000_043C, '0, '1, 0, 1'b0, lat, rd);
    check("rd_latency", lat, 10);
    check("rd_data", rd, dead);
    check("ack_one_cycle", dram_ack, 1'b0);
    check("data_held", dram_data_o, dead);
    req(1'b0, 32'h0000_8420, '0, '0, 0, 1'b0, lat, rd);
    check("alias_data", rd, dead);

    // Latency 1 on the second instance.
    f_cs = 1'b1; f_we = 1'b1; f_addr = 32'h0000_0040; f_data_i = {8{32'h1234_5678}};
    @(posedge clk); #1;
    check("fast_accept_ack", f_ack, 1'b0);
    check("fast_accept_busy", f_busy, 1'b1);
    @(posedge clk); #1;
    check("fast_wr_ack", f_ack, 1'b1);
    f_cs = 1'b0;
    @(posedge clk); #1;
    check("fast_idle_busy", f_busy, 1'b0);
    f_cs = 1'b1; f_we = 1'b0; f_data_i = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("fast_rd_ack", f_ack, 1'b1);
    check("fast_rd_data", f_data_o, {8{32'h1234_5678}});
    f_cs = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("fast_ack_low", f_ack, 1'b0);
    check("fast_data_held", f_data_o, {8{32'h1234_5678}});

    // Back-to-back: write idx 3 with cs held, read idx 7 straight after.
    req(1'b1, 32'h0000_00E0, {8{32'hA5A5_0007}}, '0, 0, 1'b0, lat, rd);
    req(1'b1, 32'h0000_0060, {8{32'hC0DE_0003}}, {8{32'hBAD0_BAD0}}, 0, 1'b1, lat, rd);
    check("b2b_wr_latency", lat, 10);
    req(1'b0, 32'h0000_00E0, '0, '1, 1, 1'b0, lat, rd);
    check("b2b_rd_latency", lat, 10);
    check("b2b_rd7", rd, {8{32'hA5A5_0007}});
    req(1'b0, 32'h0000_0060, '0, '0, 0, 1'b0, lat, rd);
    check("b2b_rd3_latched", rd, {8{32'hC0DE_0003}});

    // Reset four cycles into a write of idx 5: dropped, never acked.
    req(1'b1, 32'h0000_00A0, {8{32'h5555_AAAA}}, '0, 0, 1'b0, lat, rd);
    dram_cs = 1'b1; dram_we = 1'b1; dram_addr = 32'h0000_00A0;
    dram_data_i = {8{32'h0BAD_F00D}};
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ack", dram_ack, 1'b0);
    check("midrst_busy", dram_busy, 1'b0);
    check("midrst_data", dram_data_o, '0);
    dram_cs = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    acks_seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (dram_ack) acks_seen++;
    end
    check("midrst_no_ack", acks_seen, 0);
    req(1'b0, 32'h0000_00A0, '0, '0, 0, 1'b0, lat, rd);
    check("midrst_prior_line", rd, {8{32'h5555_AAAA}});

`ifdef DRAM_LINE_RESPONDER_STATS_EN
    pulse_rst();
    check("stats_rst_rd", rd_count, 0);
    check("stats_rst_wr", wr_count, 0);
    for (int i = 0; i < 3; i++)
      req(1'b1, 32'(i) << 5, {8{32'(i + 100)}}, '0, 0, 1'b0, lat, rd);
    for (int i = 0; i < 2; i++)
      req(1'b0, 32'(i) << 5, '0, '0, 0, 1'b0, lat, rd);
    check("stats_wr", wr_count, 3);
    check("stats_rd", rd_count, 2);
    pulse_rst();
    check("stats_clr_rd", rd_count, 0);
    check("stats_clr_wr", wr_count, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
